// File: rtl/ptx_pkg.sv
// Shared types and helpers for the parallel-to-serial lane transmitter.
package ptx_pkg;

  typedef enum logic [0:0] {
    StTrain = 1'b0,
    StRun   = 1'b1
  } ptx_state_e;

  localparam logic [7:0] PtxIdleSym = 8'hBC;

  // Counter width for a 0..n-1 counter; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ptx_serial_lanes_if.sv
// Load handshake between the lane source and the serializer.
interface ptx_serial_lanes_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8
) ();

  logic [LANES*WIDTH-1:0] data_in;
  logic [LANES-1:0]       valid_in;
  logic                   load_ack;

  modport master (
    output data_in,
    output valid_in,
    input  load_ack
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output load_ack
  );

endinterface

// File: rtl/ptx_frame_counter.sv
// Bit/lane position counters and the registered frame-load strobe.
module ptx_frame_counter
  import ptx_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     run_i,
  input  logic                     train_last_i,
  output logic [cnt_w(WIDTH)-1:0] bit_cnt_o,
  output logic [cnt_w(LANES)-1:0] lane_cnt_o,
  output logic                     sym_end_o,
  output logic                     frame_end_o,
  output logic                     load_ack_o
);

  localparam int unsigned BitW  = cnt_w(WIDTH);
  localparam int unsigned LaneW = cnt_w(LANES);
  localparam logic [BitW-1:0]  BitMax  = BitW'(WIDTH - 1);
  localparam logic [LaneW-1:0] LaneMax = LaneW'(LANES - 1);

  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [LaneW-1:0] lane_cnt_q, lane_cnt_d;
  logic             load_ack_q, load_ack_d;
  logic             sym_end, lane_last, frame_end;

  always_comb begin
    sym_end    = (bit_cnt_q == BitMax);
    lane_last  = (lane_cnt_q == LaneMax);
    frame_end  = sym_end && lane_last;
    bit_cnt_d  = sym_end ? '0 : bit_cnt_q + 1'b1;
    lane_cnt_d = lane_cnt_q;
    // Lanes only advance in RUN so the first data frame starts at lane 0.
    if (run_i && sym_end) begin
      lane_cnt_d = lane_last ? '0 : lane_cnt_q + 1'b1;
    end
    load_ack_d = run_i ? frame_end : (sym_end && train_last_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt_q  <= '0;
      lane_cnt_q <= '0;
      load_ack_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      lane_cnt_q <= lane_cnt_d;
      load_ack_q <= load_ack_d;
    end
  end

  assign bit_cnt_o   = bit_cnt_q;
  assign lane_cnt_o  = lane_cnt_q;
  assign sym_end_o   = sym_end;
  assign frame_end_o = frame_end;
  assign load_ack_o  = load_ack_q;

endmodule

// File: rtl/ptx_serial_lanes.sv
// LANES x WIDTH parallel-to-serial transmitter with post-reset training and link-idle detect.
module ptx_serial_lanes
  import ptx_pkg::*;
#(
  parameter int unsigned      LANES       = 4,
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] IDLE_SYM    = WIDTH'(PtxIdleSym),
  parameter int unsigned      TRAIN_SYMS  = 4,
  parameter int unsigned      IDLE_FRAMES = 2,
  parameter bit               MSB_FIRST   = 1'b1
) (
  input  logic                     clk_32f,
  input  logic                     reset,
  ptx_serial_lanes_if.slave        bus,
  output logic                     data_out,
  output logic                     training,
  output logic                     link_idle
);

  localparam int unsigned BitW   = cnt_w(WIDTH);
  localparam int unsigned LaneW  = cnt_w(LANES);
  localparam int unsigned TrainW = cnt_w(TRAIN_SYMS);
  localparam int unsigned IdleW  = cnt_w(IDLE_FRAMES);
  localparam logic [TrainW-1:0] TrainMax = TrainW'(TRAIN_SYMS - 1);
  localparam logic [IdleW-1:0]  IdleMax  = IdleW'(IDLE_FRAMES - 1);

  ptx_state_e state_q, state_d;

  logic [TrainW-1:0]           train_cnt_q, train_cnt_d;
  logic [IdleW-1:0]            idle_cnt_q, idle_cnt_d;
  logic                        link_idle_q, link_idle_d;
  logic                        data_out_q, data_out_d;
  logic [LANES-1:0][WIDTH-1:0] frame_q, frame_d, frame_in;

  logic [BitW-1:0]  bit_cnt;
  logic [LaneW-1:0] lane_cnt;
  logic [BitW-1:0]  bit_idx;
  logic [WIDTH-1:0] cur_sym;
  logic             sym_end, frame_end, train_last, load;

  assign train_last = (train_cnt_q == TrainMax);
  assign load       = bus.load_ack;

  ptx_frame_counter #(
    .LANES(LANES),
    .WIDTH(WIDTH)
  ) u_frame_counter (
    .clk_i       (clk_32f),
    .rst_i       (reset),
    .run_i       (state_q == StRun),
    .train_last_i(train_last),
    .bit_cnt_o   (bit_cnt),
    .lane_cnt_o  (lane_cnt),
    .sym_end_o   (sym_end),
    .frame_end_o (frame_end),
    .load_ack_o  (bus.load_ack)
  );

  // Substitute the idle symbol on every lane whose valid bit is low.
  always_comb begin
    frame_in = '0;
    for (int i = 0; i < LANES; i++) begin
      frame_in[i] = bus.valid_in[i] ? bus.data_in[i*WIDTH +: WIDTH] : IDLE_SYM;
    end
  end

  // On the load edge lane 0 comes straight from the mux, since the buffer loads on that same edge.
  always_comb begin
    cur_sym = IDLE_SYM;
    if (load) begin
      cur_sym = frame_in[0];
    end else if (state_q == StRun) begin
      cur_sym = frame_q[lane_cnt];
    end
    bit_idx    = MSB_FIRST ? (BitW'(WIDTH - 1) - bit_cnt) : bit_cnt;
    data_out_d = cur_sym[bit_idx];
  end

  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    frame_d     = frame_q;
    idle_cnt_d  = idle_cnt_q;
    link_idle_d = link_idle_q;

    if (state_q == StTrain && sym_end) begin
      train_cnt_d = train_last ? '0 : train_cnt_q + 1'b1;
    end

    if (load) begin
      state_d = StRun;
      frame_d = frame_in;
      if (|bus.valid_in) begin
        idle_cnt_d  = '0;
        link_idle_d = 1'b0;
      end else if (!link_idle_q) begin
        if (idle_cnt_q == IdleMax) begin
          link_idle_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= StTrain;
      train_cnt_q <= '0;
      frame_q     <= '0;
      idle_cnt_q  <= '0;
      link_idle_q <= 1'b0;
      data_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      train_cnt_q <= train_cnt_d;
      frame_q     <= frame_d;
      idle_cnt_q  <= idle_cnt_d;
      link_idle_q <= link_idle_d;
      data_out_q  <= data_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign training  = (state_q == StTrain);
  assign link_idle = link_idle_q;

  // Every frame end in RUN must be followed by a load strobe.
  frame_end_ack_a: assert property (
    @(posedge clk_32f) disable iff (reset) (state_q == StRun && frame_end) |=> bus.load_ack
  );

endmodule

// File: tb/tb_ptx_serial_lanes.sv
// Scoreboard bench: default 4x8 MSB-first instance plus a 2x4 LSB-first instance.
module tb_ptx_serial_lanes;

  typedef struct {
    int          nbits;
    logic [31:0] bits;
    logic        trn;
    logic        idle;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [2];
  logic dout [2];
  logic ack [2];
  logic trn [2];
  logic idl [2];
  logic dout0, trn0, idl0, dout1, trn1, idl1;

  ptx_serial_lanes_if #(.LANES(4), .WIDTH(8)) bus0 ();
  ptx_serial_lanes_if #(.LANES(2), .WIDTH(4)) bus1 ();

  ptx_serial_lanes #(
    .LANES(4), .WIDTH(8), .IDLE_SYM(8'hBC), .TRAIN_SYMS(4), .IDLE_FRAMES(2), .MSB_FIRST(1'b1)
  ) u_dut0 (
    .clk_32f  (clk),
    .reset    (rst[0]),
    .bus      (bus0),
    .data_out (dout0),
    .training (trn0),
    .link_idle(idl0)
  );

  ptx_serial_lanes #(
    .LANES(2), .WIDTH(4), .IDLE_SYM(4'hA), .TRAIN_SYMS(4), .IDLE_FRAMES(2), .MSB_FIRST(1'b0)
  ) u_dut1 (
    .clk_32f  (clk),
    .reset    (rst[1]),
    .bus      (bus1),
    .data_out (dout1),
    .training (trn1),
    .link_idle(idl1)
  );

  assign dout[0] = dout0;
  assign dout[1] = dout1;
  assign trn[0]  = trn0;
  assign trn[1]  = trn1;
  assign idl[0]  = idl0;
  assign idl[1]  = idl1;
  assign ack[0]  = bus0.load_ack;
  assign ack[1]  = bus1.load_ack;

  rec_t        sbq [2][$];
  rec_t        cur [2];
  bit          col [2];
  bit          arm [2];
  bit          prev_rst [2];
  bit          closing [2];
  int          n [2];
  logic [31:0] word [2];
  int          n_checks = 0;
  int          n_fail = 0;

  // Monitor: a release or load_ack arms capture of the next frame, which is checked on completion.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst[g]) begin
        if (prev_rst[g]) begin
          n_checks++;
          if ({dout[g], ack[g], trn[g], idl[g]} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_values dut%0d: {data_out,load_ack,training,link_idle} got %b want 0010",
                     g, {dout[g], ack[g], trn[g], idl[g]});
          end
        end
        col[g] = 1'b0;
        arm[g] = 1'b0;
      end else begin
        if (arm[g]) begin
          arm[g] = 1'b0;
          if (sbq[g].size() > 0) begin
            cur[g]  = sbq[g].pop_front();
            col[g]  = 1'b1;
            n[g]    = 0;
            word[g] = '0;
          end else if (!closing[g]) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_load dut%0d: got a frame start with empty queue, want none", g);
          end
        end
        if (col[g]) begin
          word[g] = {word[g][30:0], dout[g]};
          n[g]++;
          n_checks++;
          if ({ack[g], trn[g], idl[g]} !== {(n[g] == cur[g].nbits), cur[g].trn, cur[g].idle}) begin
            n_fail++;
            $display("FAIL frame_status dut%0d bit %0d: {load_ack,training,link_idle} got %b want %b",
                     g, n[g], {ack[g], trn[g], idl[g]},
                     {(n[g] == cur[g].nbits), cur[g].trn, cur[g].idle});
          end
          if (n[g] == cur[g].nbits) begin
            col[g] = 1'b0;
            n_checks++;
            if (word[g] !== cur[g].bits) begin
              n_fail++;
              $display("FAIL serial_word dut%0d: got %h want %h", g, word[g], cur[g].bits);
            end
          end
        end
        if (ack[g] || prev_rst[g]) arm[g] = 1'b1;
      end
      prev_rst[g] = rst[g];
    end
  end

  task automatic push_rec(input int g, input int nbits, input logic [31:0] bits,
                          input logic t, input logic idle);
    rec_t r;
    r.nbits = nbits;
    r.bits  = bits;
    r.trn   = t;
    r.idle  = idle;
    sbq[g].push_back(r);
  endtask

  task automatic wait_ack(input int g);
    int t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (!ack[g] && t < 200);
    if (!ack[g]) begin
      $display("FAIL ack_timeout dut%0d: load_ack got 0 for 200 cycles, want a pulse", g);
      $fatal(1, "bench stopped: no load_ack");
    end
  endtask

  // Drive one frame during its load_ack cycle and queue the expected serial word.
  task automatic send(input int g, input logic [31:0] data, input logic [3:0] valid,
                      input logic [31:0] exp, input logic idle);
    wait_ack(g);
    if (g == 0) begin
      bus0.data_in  = data;
      bus0.valid_in = valid;
      push_rec(0, 32, exp, 1'b0, idle);
    end else begin
      bus1.data_in  = data[7:0];
      bus1.valid_in = valid[1:0];
      push_rec(1, 8, exp, 1'b0, idle);
    end
  endtask

  task automatic drain(input int g);
    int t = 0;
    while ((sbq[g].size() != 0 || col[g]) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sbq[g].size() != 0 || col[g]) begin
      $display("FAIL drain_timeout dut%0d: got %0d frames pending, want 0", g, sbq[g].size());
      $fatal(1, "bench stopped: scoreboard did not drain");
    end
  endtask

  initial begin
    rst[0]        = 1'b1;
    rst[1]        = 1'b1;
    bus0.data_in  = '0;
    bus0.valid_in = '0;
    bus1.data_in  = '0;
    bus1.valid_in = '0;

    repeat (3) @(posedge clk);
    push_rec(0, 32, 32'hBCBCBCBC, 1'b1, 1'b0);
    #1 rst[0] = 1'b0;

    send(0, 32'hCCDDEEFF, 4'hF, 32'hFFEEDDCC, 1'b0);
    send(0, {8'($urandom), 8'($urandom), 8'h77, 8'($urandom)}, 4'b0010, 32'hBC77BCBC, 1'b0);
    send(0, $urandom, 4'h0, 32'hBCBCBCBC, 1'b0);
    send(0, $urandom, 4'h0, 32'hBCBCBCBC, 1'b1);
    send(0, $urandom, 4'h0, 32'hBCBCBCBC, 1'b1);
    send(0, {24'($urandom), 8'h5A}, 4'h1, 32'h5ABCBCBC, 1'b0);
    send(0, $urandom, 4'h0, 32'hBCBCBCBC, 1'b0);
    send(0, $urandom, 4'h0, 32'hBCBCBCBC, 1'b1);
    send(0, $urandom, 4'h0, 32'hBCBCBCBC, 1'b1);

    // Abandon that frame with a reset while bit 13 is on the line.
    @(posedge clk);
    repeat (13) @(posedge clk);
    #1 rst[0] = 1'b1;
    repeat (2) @(posedge clk);
    push_rec(0, 32, 32'hBCBCBCBC, 1'b1, 1'b0);
    #1 rst[0] = 1'b0;

    send(0, 32'h01234567, 4'hF, 32'h67452301, 1'b0);
    closing[0] = 1'b1;
    drain(0);
    @(posedge clk);
    #1 rst[0] = 1'b1;

    @(posedge clk);
    push_rec(1, 16, 32'h5555, 1'b1, 1'b0);
    #1 rst[1] = 1'b0;

    send(1, 32'h3C, 4'b0011, 32'h3C, 1'b0);
    send(1, 32'h56, 4'b0001, 32'h65, 1'b0);
    send(1, 32'h00, 4'b0000, 32'h55, 1'b0);
    send(1, 32'hF0, 4'b0000, 32'h55, 1'b1);
    closing[1] = 1'b1;
    drain(1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
